// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch stage and its next-PC helper.
package cpu_pkg;

  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_STEP  = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic               valid;
  } if_id_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC select and instruction-memory range check.
// Purely combinational; the fetch FSM picks the select.
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic [31:0] pc_i,
  input  pc_sel_t     sel_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_next_o,
  output logic [31:0] pc_plus4_o,
  output logic        oor_o
);

  // 33 bits so a full 2^30-word memory does not overflow the limit
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

  logic [31:0] w_plus4;
  logic [31:0] w_target;

  assign w_plus4    = pc_i + PC_INC;
  assign w_target   = align_pc(redirect_pc_i);
  assign pc_plus4_o = w_plus4;
  assign oor_o      = {1'b0, pc_i} >= PC_LIMIT;

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      PC_STEP:  pc_next_o = w_plus4;
      PC_REDIR: pc_next_o = w_target;
      default:  pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, fills IF/ID.
// BOOT for one cycle after reset, HALT when the PC leaves imem.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          MEM_WORDS = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [31:0]        imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_pc_plus4_o,
  output logic               if_valid_o,
  output logic               halted_o
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  if_id_t       r_ifid;

  pc_sel_t      w_sel;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_pc_plus4;
  logic         w_oor;
  logic         w_capture;
  logic         w_flush;
  logic         w_drop_valid;

  pc_next_logic #(
    .MEM_WORDS (MEM_WORDS)
  ) u_pc_next (
    .pc_i          (r_pc),
    .sel_i         (w_sel),
    .redirect_pc_i (redirect_pc_i),
    .pc_next_o     (w_pc_next),
    .pc_plus4_o    (w_pc_plus4),
    .oor_o         (w_oor)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_sel        = PC_HOLD;
    w_capture    = 1'b0;
    w_flush      = 1'b0;
    w_drop_valid = 1'b0;
    unique case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          w_sel   = PC_REDIR;
          w_flush = 1'b1;
        end else if (w_oor) begin
          w_state_nxt  = HALT;
          w_drop_valid = 1'b1;
        end else if (!stall_i) begin
          w_sel     = PC_STEP;
          w_capture = 1'b1;
        end
      end
      HALT: begin
        if (redirect_i) begin
          w_sel       = PC_REDIR;
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ifid <= '0;
    end else if (w_capture) begin
      r_ifid.instr    <= imem_instr_i;
      r_ifid.pc       <= r_pc;
      r_ifid.pc_plus4 <= w_pc_plus4;
      r_ifid.valid    <= 1'b1;
    end else if (w_flush) begin
      r_ifid.instr <= '0;
      r_ifid.valid <= 1'b0;
    end else if (w_drop_valid) begin
      r_ifid.valid <= 1'b0;
    end
  end

  assign imem_addr_o   = r_pc;
  assign if_instr_o    = r_ifid.instr;
  assign if_pc_o       = r_ifid.pc;
  assign if_pc_plus4_o = r_ifid.pc_plus4;
  assign if_valid_o    = r_ifid.valid;
  assign halted_o      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 32-word patterned imem.
// Word n of memory reads back as 32'h1000_0000 + n.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC  (32'h0),
    .MEM_WORDS (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc),
    .if_pc_plus4_o (if_pc4),
    .if_valid_o    (if_valid),
    .halted_o      (halted)
  );

  assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] pc4, input logic v, input logic [31:0] addr,
                         input logic h);
    chk({tag, ".instr"}, if_instr, ins);
    chk({tag, ".pc"}, if_pc, pc);
    chk({tag, ".pc4"}, if_pc4, pc4);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".halt"}, {31'd0, halted}, {31'd0, h});
  endtask

  initial begin
    rst_n    = 1'b0;
    stall    = 1'b0;
    redir    = 1'b0;
    redir_pc = 32'h0;
    step();
    step();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    rst_n = 1'b1;
    step();
    chk_all("boot", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("w0", 32'h1000_0000, 32'h0, 32'h4, 1'b1, 32'h4, 1'b0);
    step();
    chk_all("w1", 32'h1000_0001, 32'h4, 32'h8, 1'b1, 32'h8, 1'b0);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'h1000_0001, 32'h4, 32'h8, 1'b1, 32'h8, 1'b0);
    end
    stall = 1'b0;
    step();
    chk_all("w2", 32'h1000_0002, 32'h8, 32'hC, 1'b1, 32'hC, 1'b0);

    stall    = 1'b1;
    redir    = 1'b1;
    redir_pc = 32'h0000_0016;
    step();
    chk_all("redir", 32'h0, 32'h8, 32'hC, 1'b0, 32'h14, 1'b0);
    stall = 1'b0;
    redir = 1'b0;
    step();
    chk_all("w5", 32'h1000_0005, 32'h14, 32'h18, 1'b1, 32'h18, 1'b0);

    for (int i = 0; i < 25; i++) step();
    step();
    chk_all("w31", 32'h1000_001F, 32'd124, 32'd128, 1'b1, 32'd128, 1'b0);
    step();
    chk_all("halt", 32'h1000_001F, 32'd124, 32'd128, 1'b0, 32'd128, 1'b1);
    stall = 1'b1;
    step();
    chk_all("halt2", 32'h1000_001F, 32'd124, 32'd128, 1'b0, 32'd128, 1'b1);
    stall    = 1'b0;
    redir    = 1'b1;
    redir_pc = 32'h0;
    step();
    chk_all("unhalt", 32'h1000_001F, 32'd124, 32'd128, 1'b0, 32'h0, 1'b0);
    redir = 1'b0;
    step();
    chk_all("resume", 32'h1000_0000, 32'h0, 32'h4, 1'b1, 32'h4, 1'b0);

    for (int i = 0; i < 9; i++) step();
    chk_all("pc40", 32'h1000_0009, 32'd36, 32'd40, 1'b1, 32'd40, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("inrst", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("boot2", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk_all("w0b", 32'h1000_0000, 32'h0, 32'h4, 1'b1, 32'h4, 1'b0);

    redir    = 1'b1;
    redir_pc = 32'h0000_0200;
    step();
    chk_all("oor_run", 32'h0, 32'h0, 32'h4, 1'b0, 32'h200, 1'b0);
    redir = 1'b0;
    step();
    chk_all("oor_halt", 32'h0, 32'h0, 32'h4, 1'b0, 32'h200, 1'b1);
    step();
    chk_all("oor_hold", 32'h0, 32'h0, 32'h4, 1'b0, 32'h200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the instruction memory. Owns the program counter and drives the memory's byte address. Captures the returned word into an IF/ID holding register with a valid flag for the decoder. Supports stall, branch/jump redirect with flush, and a halt state when the PC leaves the instruction-memory range.

Parameters:
RESET_PC, 0, byte address loaded into PC on reset
MEM_WORDS, 32, instruction-memory depth in 32-bit words; legal PCs are 0 .. MEM_WORDS*4-4

Ports:
clk_i  input  1  single clock, rising edge
rst_i  input  1  asynchronous, active-low reset
stall_i  input  1  hold PC and IF/ID register (hazard from downstream)
redirect_i  input  1  branch/jump taken this cycle
redirect_pc_i  input  32  target byte address for redirect
imem_addr_o  output  32  byte address to instruction memory (= PC)
imem_instr_i  input  32  instruction word returned combinationally by memory
if_instr_o  output  32  captured instruction
if_pc_o  output  32  PC of captured instruction
if_pc_plus4_o  output  32  if_pc_o + 4
if_valid_o  output  1  captured instruction is valid
halted_o  output  1  fetch stopped, PC out of range

Behaviour:
- Reset (rst_i=0, async, immediate): pc=RESET_PC, state=BOOT, if_instr_o=0, if_pc_o=0, if_pc_plus4_o=0, if_valid_o=0, halted_o=0. Reset mid-operation discards everything in flight.
- imem_addr_o = pc register, combinational, in all states; no other logic on the path.
- States: BOOT, RUN, HALT.
- BOOT: exactly one cycle after reset release; no capture, if_valid_o stays 0; next edge -> RUN. stall_i and redirect_i are ignored in BOOT.
- RUN, per rising edge, priority redirect > out-of-range > stall > advance:
  - redirect_i=1: pc <= {redirect_pc_i[31:2],2'b00} (low bits forced to 0); if_valid_o<=0, if_instr_o<=0 (flush); stays RUN. Wins over a simultaneous stall_i.
  - pc >= MEM_WORDS*4 (and no redirect): -> HALT; if_valid_o<=0; halted_o<=1; pc holds.
  - stall_i=1: pc and all if_* outputs hold their values, including if_valid_o.
  - otherwise (advance): if_instr_o<=imem_instr_i, if_pc_o<=pc, if_pc_plus4_o<=pc+4, if_valid_o<=1, pc<=pc+4.
- Latency: the word at address A appears on if_instr_o one cycle after imem_addr_o=A, provided no stall or redirect occurs.
- HALT: pc and if_* hold, if_valid_o=0, halted_o=1. redirect_i=1 -> pc<=aligned target, halted_o<=0, -> RUN. stall_i is ignored.
- A redirect to an out-of-range target enters RUN and then HALTs on the next edge; no instruction is captured.
- Arithmetic: pc+4 is 32-bit modulo 2^32; wrap is unreachable unless MEM_WORDS covers the full 2^30-word space.
- An all-zero instruction word (sll nop) is captured like any other word; it has no special meaning to this block.

Decomposition:
- Shared package (cpu_pkg): fetch state enum {BOOT,RUN,HALT}, INSTR_W=32, PC_INC=4, ALIGN_MASK=32'hFFFF_FFFC.
- One sub-module, pc_next_logic: combinational next-PC select (redirect / hold / +4) plus the out-of-range compare. The state machine and IF/ID register stay in fetch_stage.

Test Plan:
- Reset then free run, memory word n = 32'h1000_0000+n -> cycle 1: if_valid_o=0 (BOOT); cycle 2: if_instr_o=32'h1000_0000, if_pc_o=0, if_pc_plus4_o=4; then sequential pc 4, 8, 12 with matching words.
- stall_i=1 for 3 cycles while pc=8 -> imem_addr_o stays 8, if_instr_o/if_pc_o/if_valid_o hold; after release the next capture is word 2, with no skip and no duplicate.
- redirect_i=1, redirect_pc_i=32'h0000_0016, same cycle as stall_i=1 -> next cycle pc=32'h14, if_valid_o=0; the following capture is word 5 with if_pc_o=32'h14.
- Free run to pc=124 with MEM_WORDS=32 -> word 31 captured, pc=128, then halted_o=1 and if_valid_o=0; redirect to 0 -> halted_o=0 and fetch resumes at word 0 after one cycle.
- Assert rst_i=0 asynchronously mid-run at pc=40 -> all outputs zero without a clock edge, imem_addr_o=RESET_PC; after release, BOOT is repeated.
- Redirect to 32'h0000_0200 (out of range) -> one RUN cycle with no capture, then HALT with halted_o=1.
